// File: rtl/freq_div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// freq_div_pkg
// Shared types and constants for the programmable frequency divider controller.
//   state_t     : controller state (IDLE, RUN, DRAIN)
//   MIN_DIV     : smallest legal divide ratio; smaller requests are raised to it
//   DEFAULT_DIV : ratio in force after reset (20 -> 500 kHz from clk_10M)
// Optional feature macro used by the controller: FREQ_DIV_CTRL_CNT_EN
// -----------------------------------------------------------------------------
package freq_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MIN_DIV     = 2;
    localparam int DEFAULT_DIV = 20;

endpackage

// File: rtl/freq_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// freq_div_ctrl_if
// Control/status bundle between a user and freq_div_ctrl.
//   run        : level request to generate output           (master -> slave)
//   cfg_valid  : new ratio offered on cfg_div               (master -> slave)
//   cfg_div    : requested divide ratio                     (master -> slave)
//   cfg_ready  : ratio accepted when cfg_valid && cfg_ready (slave -> master)
//   clk_out    : divided clock                              (slave -> master)
//   tick       : one-cycle pulse on first cycle of a period (slave -> master)
//   busy       : generator active (RUN or DRAIN)            (slave -> master)
//   div_cur    : ratio currently in force                   (slave -> master)
//   period_cnt : 16-bit tick counter, only with FREQ_DIV_CTRL_CNT_EN defined
// -----------------------------------------------------------------------------
interface freq_div_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             run;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] div_cur;
`ifdef FREQ_DIV_CTRL_CNT_EN
    logic [15:0]      period_cnt;

    modport master (
        output run, cfg_valid, cfg_div,
        input  cfg_ready, clk_out, tick, busy, div_cur, period_cnt
    );
    modport slave (
        input  run, cfg_valid, cfg_div,
        output cfg_ready, clk_out, tick, busy, div_cur, period_cnt
    );
`else
    modport master (
        output run, cfg_valid, cfg_div,
        input  cfg_ready, clk_out, tick, busy, div_cur
    );
    modport slave (
        input  run, cfg_valid, cfg_div,
        output cfg_ready, clk_out, tick, busy, div_cur
    );
`endif
endinterface

// File: rtl/freq_div_ctrl_core.sv
// -----------------------------------------------------------------------------
// freq_div_core
// Period counter with wrap detect and registered clk_out / tick generation.
//   clk_10M : system clock (rising edge)
//   reset   : synchronous, active-high
//   en      : generator active in the coming cycle
//   div     : ratio for the coming cycle (sampled when a new period starts)
//   wrap    : current cycle is the last of its period (cnt == N-1)
//   clk_out : high for the first N - floor(N/2) cycles of each period
//   tick    : high on the first cycle of each period
// -----------------------------------------------------------------------------
module freq_div_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk_10M,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             wrap,
    output logic             clk_out,
    output logic             tick
);
    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_eff;

    // div_q holds the ratio of the running period; it only changes when a
    // new period starts, so a ratio update can never cut a period short.
    assign wrap    = active && (cnt == div_q - CNT_W'(1));
    assign cnt_nxt = (!active || wrap) ? '0 : cnt + CNT_W'(1);
    // The first cycle of a new period must already use the new ratio.
    assign div_eff = (cnt_nxt == '0) ? div : div_q;

    always_ff @(posedge clk_10M) begin
        if (reset || !en) begin
            active  <= 1'b0;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            active  <= 1'b1;
            cnt     <= cnt_nxt;
            tick    <= (cnt_nxt == '0);
            // Ceil(N/2) high cycles: odd ratios get the extra high cycle.
            clk_out <= (cnt_nxt < (div_eff - (div_eff >> 1)));
        end
    end

    always_ff @(posedge clk_10M) begin
        if (en && (cnt_nxt == '0)) begin
            div_q <= div;
        end
    end

endmodule

// File: rtl/freq_div_ctrl.sv
// -----------------------------------------------------------------------------
// freq_div_ctrl
// Run-time controller for the programmable frequency divider. Starts/stops
// the divided clock on period boundaries and accepts new ratios through a
// valid/ready handshake; new ratios take effect only at a period wrap.
//   clk_10M : system clock (rising edge)
//   reset   : synchronous, active-high
//   bus     : freq_div_ctrl_if slave modport (run, cfg_*, clk_out, tick,
//             busy, div_cur, and period_cnt when enabled)
// Optional feature: define FREQ_DIV_CTRL_CNT_EN to add the 16-bit period_cnt
// output counting ticks (wraps at 16'hFFFF, holds in IDLE).
// -----------------------------------------------------------------------------
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = DEFAULT_DIV
) (
    input  logic            clk_10M,
    input  logic            reset,
    freq_div_ctrl_if.slave  bus
);
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        if (d < CNT_W'(MIN_DIV)) begin
            return CNT_W'(MIN_DIV);
        end
        return d;
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] cfg_clamped;
    logic             pend_vld;
    logic             pend_vld_nxt;
    logic             ready_q;
    logic             busy_q;
    logic             accept;
    logic             load_pend;
    logic             wrap;
    logic             core_clk_out;
    logic             core_tick;

    assign accept      = bus.cfg_valid && ready_q;
    assign cfg_clamped = clamp_div(bus.cfg_div);

    always_comb begin
        state_nxt    = state;
        div_nxt      = div_cur;
        pend_vld_nxt = pend_vld;
        load_pend    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    div_nxt = cfg_clamped;
                end
                if (bus.run) begin
                    state_nxt = RUN;
                end
            end
            RUN, DRAIN: begin
                if (wrap) begin
                    state_nxt = bus.run ? RUN : IDLE;
                    // A ratio accepted on the wrap cycle bypasses the pending
                    // register; ready is only high when nothing is pending.
                    if (accept) begin
                        div_nxt = cfg_clamped;
                    end else if (pend_vld) begin
                        div_nxt = pend_div;
                    end
                    pend_vld_nxt = 1'b0;
                end else begin
                    state_nxt = bus.run ? RUN : DRAIN;
                    if (accept) begin
                        pend_vld_nxt = 1'b1;
                        load_pend    = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_10M) begin
        if (reset) begin
            state    <= IDLE;
            div_cur  <= CNT_W'(DEF_DIV);
            pend_vld <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cur  <= div_nxt;
            pend_vld <= pend_vld_nxt;
            ready_q  <= !pend_vld_nxt;
            busy_q   <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk_10M) begin
        if (load_pend) begin
            pend_div <= cfg_clamped;
        end
    end

    freq_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_10M (clk_10M),
        .reset   (reset),
        .en      (state_nxt != IDLE),
        .div     (div_nxt),
        .wrap    (wrap),
        .clk_out (core_clk_out),
        .tick    (core_tick)
    );

    assign bus.cfg_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.div_cur   = div_cur;
    assign bus.clk_out   = core_clk_out;
    assign bus.tick      = core_tick;

`ifdef FREQ_DIV_CTRL_CNT_EN
    logic [15:0] period_cnt;

    // Counts every tick; natural 16-bit wrap, and no ticks occur in IDLE.
    always_ff @(posedge clk_10M) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (core_tick) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end

    assign bus.period_cnt = period_cnt;
`endif

endmodule
